// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_reg_pkg                                                   |
// | Stall-vector indices, bubble-mode constants and action selection     |
// | shared by the pipeline stage register.                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pipe_stage_reg_pkg;

  localparam int c_STG_IF  = 0;
  localparam int c_STG_ID  = 1;
  localparam int c_STG_IS  = 2;
  localparam int c_STG_EX  = 3;
  localparam int c_STG_MEM = 4;
  localparam int c_STG_WB  = 5;

  localparam int c_ZB_KEEP  = 0;
  localparam int c_ZB_CLEAR = 1;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_FLUSH  = 2'd3
  } stage_act_t;

  // Priority: flush, bubble, hold, load.
  function automatic stage_act_t sel_act(input logic flush, input logic hold,
                                         input logic bubble);
    if (flush)       return ACT_FLUSH;
    else if (bubble) return ACT_BUBBLE;
    else if (hold)   return ACT_HOLD;
    else             return ACT_LOAD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter                                                          |
// | Saturating up-counter with synchronous clear over increment.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {CW{1'b1}})) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_reg                                                       |
// | Multi-channel write-back pipeline register with stall/bubble/flush   |
// | handling and saturating hold/bubble statistics.                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int AW          = 5,
  parameter int DW          = 32,
  parameter int STALL_W     = 6,
  parameter int STAGE       = c_STG_EX,
  parameter int ZERO_BUBBLE = c_ZB_CLEAR,
  parameter int CW          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [N_CH-1:0]      in_wen,
  input  logic [N_CH*AW-1:0]   in_waddr,
  input  logic [N_CH*DW-1:0]   in_wdata,
  output logic                 out_valid,
  output logic [N_CH-1:0]      out_wen,
  output logic [N_CH*AW-1:0]   out_waddr,
  output logic [N_CH*DW-1:0]   out_wdata,
  output logic [CW-1:0]        stall_cnt,
  output logic [CW-1:0]        bubble_cnt,
  input  logic                 cnt_clr
);

  // Flat layout, MSB to LSB: {valid, wen, waddr, wdata}.
  localparam int c_ADDR_LSB  = N_CH * DW;
  localparam int c_WEN_LSB   = c_ADDR_LSB + N_CH * AW;
  localparam int c_VALID_BIT = c_WEN_LSB + N_CH;
  localparam int c_SW        = c_VALID_BIT + 1;

  logic [c_SW-1:0] r_stage;
  logic [c_SW-1:0] w_stage_nxt;
  logic [c_SW-1:0] w_load;
  logic [c_SW-1:0] w_squash;
  stage_act_t      w_act;
  logic            w_hold;
  logic            w_bubble;
  logic            w_stall_inc;
  logic            w_unused_stall;

  assign w_hold         = stall[STAGE];
  assign w_bubble       = stall[STAGE] & ~stall[STAGE+1];
  assign w_unused_stall = ^stall;
  assign w_act          = sel_act(flush, w_hold, w_bubble);

  // An invalid upstream slot must never produce a write.
  assign w_load = {in_valid, in_wen & {N_CH{in_valid}}, in_waddr, in_wdata};

  always_comb begin
    w_squash = '0;
    if (ZERO_BUBBLE == c_ZB_KEEP) begin
      w_squash[c_WEN_LSB-1:0] = r_stage[c_WEN_LSB-1:0];
    end
  end

  always_comb begin
    w_stage_nxt = r_stage;
    case (w_act)
      ACT_FLUSH,
      ACT_BUBBLE: w_stage_nxt = w_squash;
      ACT_LOAD:   w_stage_nxt = w_load;
      default:    w_stage_nxt = r_stage;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stage <= '0;
    end else begin
      r_stage <= w_stage_nxt;
    end
  end

  assign out_valid = r_stage[c_VALID_BIT];
  assign out_wen   = r_stage[c_WEN_LSB +: N_CH];
  assign out_waddr = r_stage[c_ADDR_LSB +: N_CH*AW];
  assign out_wdata = r_stage[0 +: N_CH*DW];

  // Only a held real instruction counts as a stall cycle.
  assign w_stall_inc = (w_act == ACT_HOLD) & r_stage[c_VALID_BIT];

  sat_counter #(
    .CW (CW)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

  sat_counter #(
    .CW (CW)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_bubble),
    .clr   (cnt_clr),
    .count (bubble_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_stage_reg                                                    |
// | Directed self-checking bench with a per-cycle behavioural model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pipe_stage_reg;

  localparam int N_CH    = 2;
  localparam int AW      = 5;
  localparam int DW      = 32;
  localparam int STALL_W = 6;
  localparam int STAGE   = 3;
  localparam int CW      = 4;
  localparam int CMAX    = (1 << CW) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [STALL_W-1:0]   stall = '0;
  logic                 flush = 1'b0;
  logic                 in_valid = 1'b0;
  logic [N_CH-1:0]      in_wen = '0;
  logic [N_CH*AW-1:0]   in_waddr = '0;
  logic [N_CH*DW-1:0]   in_wdata = '0;
  logic                 cnt_clr = 1'b0;
  logic                 out_valid;
  logic [N_CH-1:0]      out_wen;
  logic [N_CH*AW-1:0]   out_waddr;
  logic [N_CH*DW-1:0]   out_wdata;
  logic [CW-1:0]        stall_cnt;
  logic [CW-1:0]        bubble_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  pipe_stage_reg #(
    .N_CH(N_CH), .AW(AW), .DW(DW), .STALL_W(STALL_W),
    .STAGE(STAGE), .ZERO_BUBBLE(1), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_wen(in_wen), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_wen(out_wen), .out_waddr(out_waddr), .out_wdata(out_wdata),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-channel arrays and integer counters.
  bit          m_valid;
  bit          m_wen  [N_CH];
  int unsigned m_addr [N_CH];
  logic [DW-1:0] m_data [N_CH];
  int          m_scnt;
  int          m_bcnt;

  always @(posedge clk or negedge rst) begin : model
    bit h, nx, bub;
    if (!rst) begin
      m_valid = 0; m_scnt = 0; m_bcnt = 0;
      for (int k = 0; k < N_CH; k++) begin
        m_wen[k] = 0; m_addr[k] = 0; m_data[k] = '0;
      end
    end else begin
      h   = stall[STAGE];
      nx  = stall[STAGE+1];
      bub = h && !nx;
      if (cnt_clr) begin
        m_scnt = 0; m_bcnt = 0;
      end else begin
        if (bub && m_bcnt < CMAX) m_bcnt++;
        if (!flush && h && nx && m_valid && m_scnt < CMAX) m_scnt++;
      end
      if (flush || bub) begin
        m_valid = 0;
        for (int k = 0; k < N_CH; k++) begin
          m_wen[k] = 0; m_addr[k] = 0; m_data[k] = '0;
        end
      end else if (!h) begin
        m_valid = in_valid;
        for (int k = 0; k < N_CH; k++) begin
          m_wen[k]  = in_valid && in_wen[k];
          m_addr[k] = in_waddr[k*AW +: AW];
          m_data[k] = in_wdata[k*DW +: DW];
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [N_CH-1:0]    e_wen;
    logic [N_CH*AW-1:0] e_addr;
    logic [N_CH*DW-1:0] e_data;
    if (chk_en) begin
      for (int k = 0; k < N_CH; k++) begin
        e_wen[k]            = m_wen[k];
        e_addr[k*AW +: AW]  = AW'(m_addr[k]);
        e_data[k*DW +: DW]  = m_data[k];
      end
      chk("m_valid", 64'(out_valid), 64'(m_valid));
      chk("m_wen",   64'(out_wen),   64'(e_wen));
      chk("m_waddr", 64'(out_waddr), 64'(e_addr));
      chk("m_wdata", 64'(out_wdata), 64'(e_data));
      chk("m_stall_cnt",  64'(stall_cnt),  64'(m_scnt));
      chk("m_bubble_cnt", 64'(bubble_cnt), 64'(m_bcnt));
    end
  end

  task automatic apply(input logic v, input logic [1:0] wen, input logic [9:0] addr,
                       input logic [63:0] data, input logic [5:0] st,
                       input logic fl, input logic clr);
    in_valid = v; in_wen = wen; in_waddr = addr; in_wdata = data;
    stall = st; flush = fl; cnt_clr = clr;
    @(posedge clk);
    #2;
  endtask

  localparam logic [5:0] ST_RUN  = 6'b000000;
  localparam logic [5:0] ST_HOLD = 6'b111000;
  localparam logic [5:0] ST_BUB  = 6'b001000;

  logic [5:0]  st_tab [8] = '{6'b000000, 6'b011000, 6'b110111, 6'b001000,
                              6'b100000, 6'b111000, 6'b001111, 6'b000111};
  logic [63:0] d_tab  [8] = '{64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_0000_0001,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_2222_3333_4444,
                              64'h8000_0000_0000_0001, 64'h0F0F_F0F0_AA55_55AA,
                              64'hCAFE_F00D_1234_5678, 64'h0000_0000_0000_0000};

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_counters", 64'({stall_cnt, bubble_cnt}), 64'd0);
    chk_en = 1'b1;
    rst = 1'b1;

    apply(1, 2'b11, {5'd3, 5'd7}, {32'hAAAA_0001, 32'h5555_0002}, ST_RUN, 0, 0);
    chk("load_valid", 64'(out_valid), 64'd1);
    chk("load_wen",   64'(out_wen),   64'h3);
    chk("load_waddr", 64'(out_waddr), 64'({5'd3, 5'd7}));
    chk("load_wdata", 64'(out_wdata), {32'hAAAA_0001, 32'h5555_0002});

    for (int i = 0; i < 3; i++) begin
      apply(1, 2'b01, {5'd20, 5'd21}, 64'h1357_9BDF_2468_ACE0, ST_HOLD, 0, 0);
      chk("hold_waddr", 64'(out_waddr), 64'({5'd3, 5'd7}));
      chk("hold_wdata", 64'(out_wdata), {32'hAAAA_0001, 32'h5555_0002});
    end
    chk("hold_stall_cnt", 64'(stall_cnt), 64'd3);

    apply(1, 2'b11, {5'd1, 5'd2}, 64'h1, ST_BUB, 0, 0);
    chk("bubble_valid_wen", 64'({out_valid, out_wen}), 64'd0);
    chk("bubble_zero_data", 64'({out_waddr, out_wdata}), 64'd0);
    chk("bubble_cnt_1", 64'(bubble_cnt), 64'd1);

    apply(0, 2'b11, {5'd9, 5'd10}, 64'h1234_5678_9ABC_DEF0, ST_RUN, 0, 0);
    chk("invalid_wen", 64'({out_valid, out_wen}), 64'd0);
    chk("invalid_waddr", 64'(out_waddr), 64'({5'd9, 5'd10}));

    apply(1, 2'b10, {5'd31, 5'd1}, 64'hFEDC_BA98_7654_3210, ST_RUN, 0, 0);
    chk("load2_wen", 64'(out_wen), 64'h2);
    apply(1, 2'b11, {5'd4, 5'd5}, 64'h5, ST_RUN, 1, 0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_bubble_cnt", 64'(bubble_cnt), 64'd1);

    apply(1, 2'b11, {5'd4, 5'd5}, 64'h5, ST_HOLD, 0, 0);
    chk("hold_invalid_cnt", 64'(stall_cnt), 64'd3);
    apply(1, 2'b11, {5'd4, 5'd5}, 64'h5, ST_BUB, 1, 0);
    chk("flush_bubble_counts", 64'(bubble_cnt), 64'd2);

    for (int i = 0; i < 8; i++) begin
      apply(i[0], 2'(i), 10'(i * 37), d_tab[i], st_tab[i], i == 6, 0);
    end

    apply(1, 2'b11, {5'd12, 5'd13}, 64'hABCD, ST_RUN, 0, 1);
    chk("clr_counters", 64'({stall_cnt, bubble_cnt}), 64'd0);
    for (int i = 0; i < 20; i++) apply(1, 2'b00, 10'd0, 64'd0, ST_HOLD, 0, 0);
    chk("stall_sat", 64'(stall_cnt), 64'hF);
    for (int i = 0; i < 20; i++) apply(1, 2'b00, 10'd0, 64'd0, ST_BUB, 0, 0);
    chk("bubble_sat", 64'(bubble_cnt), 64'hF);
    apply(1, 2'b00, 10'd0, 64'd0, ST_BUB, 0, 1);
    chk("clr_over_inc", 64'(bubble_cnt), 64'd0);

    apply(1, 2'b11, {5'd17, 5'd18}, 64'h7777_8888_9999_AAAA, ST_RUN, 0, 0);
    apply(1, 2'b11, {5'd17, 5'd18}, 64'h7777_8888_9999_AAAA, ST_HOLD, 0, 0);
    rst = 1'b0;
    #1;
    chk("async_reset_data", 64'({out_valid, out_wen, out_waddr}), 64'd0);
    chk("async_reset_wdata", 64'(out_wdata), 64'd0);
    chk("async_reset_cnt", 64'({stall_cnt, bubble_cnt}), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    apply(1, 2'b01, {5'd2, 5'd6}, 64'h0000_00FF_0000_0EE0, ST_RUN, 0, 0);
    chk("post_reset_load", 64'({out_valid, out_wen, out_waddr}), 64'({1'b1, 2'b01, 5'd2, 5'd6}));

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter N_CH, default 2: number of independent write-back channels carried through the stage.
REQ-002 Parameter AW, default 5: register-address width per channel.
REQ-003 Parameter DW, default 32: data width per channel.
REQ-004 Parameter STALL_W, default 6: width of the pipeline stall vector.
REQ-005 Parameter STAGE, default 3: stall-vector index owned by this register; legal range 0..STALL_W-2.
REQ-006 Parameter ZERO_BUBBLE, default 1: 1 clears address/data on bubble or flush; 0 clears only the valid and enable bits.
REQ-007 Parameter CW, default 16: width of the stall and bubble counters.
REQ-008 clk  in  1  single clock; all state updates on its rising edge.
REQ-009 rst  in  1  reset; asynchronous, active-low.
REQ-010 stall  in  STALL_W  pipeline stall vector.
REQ-011 flush  in  1  synchronous squash of the stage content.
REQ-012 in_valid  in  1  upstream stage holds a real instruction.
REQ-013 in_wen  in  N_CH  per-channel write enable.
REQ-014 in_waddr  in  N_CH*AW  per-channel destination address; channel k occupies bits [k*AW +: AW].
REQ-015 in_wdata  in  N_CH*DW  per-channel write data; channel k occupies bits [k*DW +: DW].
REQ-016 out_valid, out_wen, out_waddr, out_wdata  out  1 / N_CH / N_CH*AW / N_CH*DW  registered copies delivered to the next stage.
REQ-017 stall_cnt  out  CW  cycles spent holding, saturating.
REQ-018 bubble_cnt  out  CW  bubbles inserted, saturating.
REQ-019 cnt_clr  in  1  synchronous clear of both counters.

Function
REQ-020 Define hold = stall[STAGE], and bubble = stall[STAGE] & ~stall[STAGE+1].
REQ-021 Each clock edge SHALL select exactly one action, in this priority order: flush, bubble, hold, load.
- Flush or bubble: out_valid=0, out_wen=0; out_waddr/out_wdata cleared to 0 if ZERO_BUBBLE=1, otherwise retained.
- Hold (stall[STAGE]=1 and stall[STAGE+1]=1): all outputs retain their values.
- Load (stall[STAGE]=0): every output takes its in_* value.
REQ-022 On load with in_valid=0, out_wen SHALL be forced to 0 regardless of in_wen; address and data are still captured.
REQ-023 Latency SHALL be exactly one cycle from load to output; there is no combinational path from any input to any output.
REQ-024 stall_cnt SHALL increment on each hold cycle in which out_valid=1, and SHALL saturate at all-ones.
REQ-025 bubble_cnt SHALL increment on each bubble cycle, and SHALL saturate at all-ones.
REQ-026 cnt_clr SHALL zero both counters and take priority over increment in the same cycle.
REQ-027 A flush in the same cycle as a bubble SHALL count as a bubble only if stall[STAGE]=1.
REQ-028 Channels SHALL be fully independent: no cross-channel priority and no address-conflict checking.

Reset
REQ-029 While rst=0, all outputs SHALL be 0 immediately (asynchronously), including both counters.
REQ-030 Deassertion of rst SHALL take effect at the next clock edge; the first edge after release performs the normal action.
REQ-031 Reset asserted mid-hold SHALL discard the held content; no recovery of it is required.

Structure
REQ-032 A shared package SHALL hold the stall-index constants (IF..WB = 0..5) and the ZERO_BUBBLE mode constants; existing global defines remain the source of the zero word and NOP register address.
REQ-033 One sub-module, sat_counter (width CW, with inc and clr inputs), SHALL be instantiated twice.
REQ-034 Stage data SHALL be a single flat register vector; no memories and no generate-per-channel logic beyond slicing.

Verification
REQ-035 Reset: rst=0 mid-stream -> all outputs read 0 within the same cycle, before any clock edge.
REQ-036 Load: N_CH=2, in_valid=1, in_wen=2'b11, addr {5'd3, 5'd7}, data {32'hAAAA_0001, 32'h5555_0002}, stall=0 -> identical values on the outputs one cycle later.
REQ-037 Hold: stall=6'b111000 for 3 cycles with out_valid=1 -> outputs stable for those 3 cycles, stall_cnt=3.
REQ-038 Bubble: stall=6'b001000 -> next cycle out_valid=0 and out_wen=0; with ZERO_BUBBLE=1, address/data read 0; bubble_cnt=1.
REQ-039 Priority: flush=1 together with stall=0 and in_valid=1 -> out_valid=0, and bubble_cnt is unchanged.
REQ-040 Saturation: CW=4, 20 consecutive bubbles -> bubble_cnt=4'hF; then cnt_clr=1 asserted together with a bubble -> bubble_cnt=0.
